// File: rtl/bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_arbiter_pkg
// Shared constants and types for the four-master round-robin bus arbiter.
// Holds the bus_def set (master count, owner index type, owner constants) and
// the global_std_def active-low enable levels, plus a grant decode helper.
// -----------------------------------------------------------------------------
package bus_arbiter_pkg;

  // global_std_def: active-low signalling levels
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // bus_def: master count and owner index
  localparam int BUS_MASTER_CH = 4;

  // BUS_OWNER_BUS: [1:0] owner index, wraps mod 4
  typedef logic [1:0] bus_owner_t;

  localparam bus_owner_t BUS_OWNER_MASTER_0 = 2'd0;
  localparam bus_owner_t BUS_OWNER_MASTER_1 = 2'd1;
  localparam bus_owner_t BUS_OWNER_MASTER_2 = 2'd2;
  localparam bus_owner_t BUS_OWNER_MASTER_3 = 2'd3;

  // Active-low one-hot grant vector {m3..m0} for a given owner.
  function automatic logic [BUS_MASTER_CH-1:0] owner_to_grnt_n(input bus_owner_t owner);
    logic [BUS_MASTER_CH-1:0] g;
    g        = {BUS_MASTER_CH{DISABLE_}};
    g[owner] = ENABLE_;
    return g;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// bus_arbiter_if
// Request/grant bundle between the four bus masters and the arbiter.
//   mX_req_n  : request from master X, active-low
//   mX_grnt_n : grant to master X, active-low, exactly one asserted
//   owner     : index of the current bus owner
// Modports: master (drives requests, observes grants) and slave (arbiter side).
// -----------------------------------------------------------------------------
interface bus_arbiter_if;
  import bus_arbiter_pkg::*;

  logic       m0_req_n;
  logic       m1_req_n;
  logic       m2_req_n;
  logic       m3_req_n;
  logic       m0_grnt_n;
  logic       m1_grnt_n;
  logic       m2_grnt_n;
  logic       m3_grnt_n;
  bus_owner_t owner;

  modport master (
    output m0_req_n, m1_req_n, m2_req_n, m3_req_n,
    input  m0_grnt_n, m1_grnt_n, m2_grnt_n, m3_grnt_n, owner
  );

  modport slave (
    input  m0_req_n, m1_req_n, m2_req_n, m3_req_n,
    output m0_grnt_n, m1_grnt_n, m2_grnt_n, m3_grnt_n, owner
  );

endinterface

// File: rtl/bus_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// bus_arb_rr_pick
// Combinational round-robin selector. Scans owner+1, owner+2, owner+3 (mod 4)
// and returns the first requester. The current owner is never a candidate.
//   i_owner : current owner index
//   i_req   : request vector {m3..m0}, active-high
//   o_next  : first requester after i_owner (i_owner when none)
//   o_found : at least one other master is requesting
// -----------------------------------------------------------------------------
module bus_arb_rr_pick
  import bus_arbiter_pkg::*;
(
  input  bus_owner_t               i_owner,
  input  logic [BUS_MASTER_CH-1:0] i_req,
  output bus_owner_t               o_next,
  output logic                     o_found
);

  // Walk from the farthest distance to the nearest so the nearest requester
  // overwrites the others and wins.
  always_comb begin
    // NOTE: every output gets a default before any conditional assignment,
    // otherwise the unassigned paths would infer latches.
    o_next  = i_owner;
    o_found = 1'b0;
    for (int d = BUS_MASTER_CH - 1; d >= 1; d--) begin
      if (i_req[bus_owner_t'(i_owner + bus_owner_t'(d))]) begin
        o_next  = bus_owner_t'(i_owner + bus_owner_t'(d));
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Non-preemptive round-robin arbiter for four bus masters with registered,
// active-low, always one-hot grants. The bus parks on the last owner when
// nobody requests, so a parked owner re-requesting is granted at once.
//   clk    : bus clock, rising edge
//   reset  : asynchronous, active-high; forces owner 0 / grant to m0
//   arb_if : slave side of bus_arbiter_if (requests in, grants/owner out)
// Parameter TIMEOUT_CYCLES (2..256): consecutive owned cycles allowed while
// another master waits; only used when BUS_ARB_TIMEOUT_EN is defined.
// Optional feature macro: BUS_ARB_TIMEOUT_EN (fairness watchdog). Undefined
// builds no counter and the owner keeps the bus for as long as it requests.
// -----------------------------------------------------------------------------
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic          clk,
  input logic          reset,
  bus_arbiter_if.slave arb_if
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
    $error("bus_arbiter: TIMEOUT_CYCLES must be in 2..256");
  end

  logic [BUS_MASTER_CH-1:0] w_req;
  bus_owner_t               w_pick;
  logic                     w_found;
  bus_owner_t               w_owner_nxt;
  bus_owner_t               r_owner;
  logic [BUS_MASTER_CH-1:0] r_grnt_n;

  // Requests are handled active-high internally.
  assign w_req = ~{arb_if.m3_req_n, arb_if.m2_req_n, arb_if.m1_req_n, arb_if.m0_req_n};

  // Single selector serves both the normal handover and the forced one.
  bus_arb_rr_pick u_pick (
    .i_owner (r_owner),
    .i_req   (w_req),
    .o_next  (w_pick),
    .o_found (w_found)
  );

`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIMIT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_hold_cnt;
  logic [7:0] w_hold_nxt;

  // The counter only runs while the owner keeps the bus and someone else is
  // waiting; any owner change or an empty queue clears it, so a lone
  // requester is never preempted.
  always_comb begin
    w_owner_nxt = r_owner;
    w_hold_nxt  = '0;
    if (w_req[r_owner]) begin
      if (w_found) begin
        if (r_hold_cnt == HOLD_LIMIT) begin
          w_owner_nxt = w_pick;
        end else begin
          w_hold_nxt = r_hold_cnt + 8'd1;
        end
      end
    end else if (w_found) begin
      w_owner_nxt = w_pick;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold_cnt <= '0;
    end else begin
      r_hold_cnt <= w_hold_nxt;
    end
  end
`else
  // Keep while requesting, hand over on release, otherwise park.
  always_comb begin
    w_owner_nxt = r_owner;
    if (!w_req[r_owner] && w_found) begin
      w_owner_nxt = w_pick;
    end
  end
`endif

  // Grants are registered from the next-owner decode so they change on the
  // same edge as owner and come straight from flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: state uses non-blocking assignments so every flop samples the
      // pre-edge values, independent of statement order.
      r_owner  <= BUS_OWNER_MASTER_0;
      r_grnt_n <= owner_to_grnt_n(BUS_OWNER_MASTER_0);
    end else begin
      r_owner  <= w_owner_nxt;
      r_grnt_n <= owner_to_grnt_n(w_owner_nxt);
    end
  end

  assign arb_if.owner     = r_owner;
  assign arb_if.m0_grnt_n = r_grnt_n[0];
  assign arb_if.m1_grnt_n = r_grnt_n[1];
  assign arb_if.m2_grnt_n = r_grnt_n[2];
  assign arb_if.m3_grnt_n = r_grnt_n[3];

endmodule
